// File: rtl/apb_pkg.sv
// Shared APB definitions: default bus widths and the IDLE/SETUP/ACCESS state
// encoding used by both the master and the slave.
package apb_pkg;

  localparam int APB_ADDR_WIDTH = 10;
  localparam int APB_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } apb_state_e;

endpackage

// File: rtl/apb_rr_arb2.sv
// Two-way round-robin grant logic with its priority pointer register.
// The pointer names the side that wins a tie; it flips to the other side on every completion.
module apb_rr_arb2 (
  input  logic       pclk,
  input  logic       preset,
  input  logic [1:0] elig,
  input  logic       adv,
  input  logic       done_idx,
  output logic       any,
  output logic       gnt_idx
);

  logic ptr;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge pclk) begin
    if (preset) begin
      ptr <= 1'b0;
    end else if (adv) begin
      ptr <= ~done_idx;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path through the block infers a latch.
    any     = |elig;
    gnt_idx = ptr;
    if (elig == 2'b01) begin
      gnt_idx = 1'b0;
    end else if (elig == 2'b10) begin
      gnt_idx = 1'b1;
    end
  end

endmodule

// File: rtl/apb_arb_master.sv
// Two-requester APB master: round-robin arbitration plus IDLE/SETUP/ACCESS sequencing.
// Define APB_TIMEOUT_EN to abort ACCESS phases that wait TIMEOUT_CYCLES without pready.
module apb_arb_master
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH     = APB_ADDR_WIDTH,
  parameter int DATA_WIDTH     = APB_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  wr0,
  input  logic                  wr1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack0,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  output logic                  pwrite,
  output logic                  pselx,
  output logic                  penable,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  apb_state_e state, state_nxt;
  logic       gnt_q;
  logic [1:0] elig;
  logic       any, gnt_idx, done, timeout;

  // A requester whose ack is high this cycle is still dropping req; do not re-grant it.
  assign elig = {req1 & ~ack1, req0 & ~ack0};

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0] access_cnt;

  always_ff @(posedge pclk) begin
    if (preset) begin
      access_cnt <= '0;
    end else if (state == SETUP) begin
      access_cnt <= '0;
    end else if (state == ACCESS) begin
      access_cnt <= access_cnt + 1'b1;
    end
  end

  assign timeout = (state == ACCESS) && !pready &&
                   (access_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  assign done    = (state == ACCESS) && (pready || timeout);
  assign pselx   = (state != IDLE);
  assign penable = (state == ACCESS);

  apb_rr_arb2 u_arb (
    .pclk     (pclk),
    .preset   (preset),
    .elig     (elig),
    .adv      (done),
    .done_idx (gnt_q),
    .any      (any),
    .gnt_idx  (gnt_idx)
  );

  always_ff @(posedge pclk) begin
    if (preset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (any) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      gnt_q     <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      pwrite    <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      if (state == IDLE && any) begin
        gnt_q  <= gnt_idx;
        paddr  <= gnt_idx ? addr1  : addr0;
        pwdata <= gnt_idx ? wdata1 : wdata0;
        pwrite <= gnt_idx ? wr1    : wr0;
      end
      if (done) begin
        ack0      <= ~gnt_q;
        ack1      <= gnt_q;
        rsp_rdata <= (pready && !pwrite) ? prdata : '0;
        rsp_err   <= pready ? pslverr : 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb_arb_master.sv
// Directed self-checking bench for apb_arb_master with a small APB memory model.
// Define APB_TIMEOUT_EN for both bench and RTL to exercise the ACCESS timeout.
module tb_apb_arb_master;

  logic        pclk = 1'b0;
  logic        preset;
  logic        req0, req1, wr0, wr1;
  logic [9:0]  addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        ack0, ack1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [9:0]  paddr;
  logic [31:0] pwdata;
  logic        pwrite, pselx, penable;
  logic [31:0] prdata;
  logic        pready, pslverr;

  logic [31:0] mem [0:1023];
  int checks = 0;
  int errors = 0;

  always #5 pclk = ~pclk;

  apb_arb_master #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .pclk(pclk), .preset(preset),
    .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite), .pselx(pselx), .penable(penable),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  // Slave model: writes commit on a completing ACCESS edge, reads are combinational.
  assign prdata = mem[paddr];
  always @(posedge pclk) begin
    if (pselx && penable && pready && pwrite) mem[paddr] <= pwdata;
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // {pselx, penable, ack0, ack1, rsp_err}
  task automatic expect_ctl(input string name, input logic [4:0] exp);
    logic [4:0] got;
    got = {pselx, penable, ack0, ack1, rsp_err};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s sel/en/ack0/ack1/err got %b expected %b", name, got, exp);
    end
  endtask

  task automatic expect_word(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %08h expected %08h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    preset = 1'b1;
    req0 = 0; req1 = 0; wr0 = 0; wr1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    pready = 1'b1; pslverr = 1'b0;
    tick(); tick();
    preset = 1'b0;
    expect_ctl("reset_ctl", 5'b00000);
    expect_word("reset_rdata", rsp_rdata, 32'h0);
    expect_word("reset_bus", {12'h0, paddr, pwrite, 9'h0}, 32'h0);
    expect_word("reset_pwdata", pwdata, 32'h0);
  endtask

  task automatic test_single_write();
    req0 = 1; wr0 = 1; addr0 = 10'h010; wdata0 = 32'hDEADBEEF; pready = 1;
    tick();
    expect_ctl("wr_c1_setup", 5'b10000);
    expect_word("wr_c1_paddr", {22'h0, paddr}, 32'h010);
    expect_word("wr_c1_pwdata", pwdata, 32'hDEADBEEF);
    tick();
    expect_ctl("wr_c2_access", 5'b11000);
    tick();
    expect_ctl("wr_c3_ack0", 5'b00100);
    expect_word("wr_c3_rdata", rsp_rdata, 32'h0);
    req0 = 0;
    tick();
    expect_ctl("wr_c4_idle", 5'b00000);
    expect_word("wr_mem", mem[10'h010], 32'hDEADBEEF);
  endtask

  task automatic test_read_wait();
    req1 = 1; wr1 = 0; addr1 = 10'h010; pready = 0; pslverr = 1;
    tick();
    expect_ctl("rd_c1_setup", 5'b10000);
    tick();
    expect_ctl("rd_c2_wait", 5'b11000);
    tick();
    expect_ctl("rd_c3_wait", 5'b11000);
    expect_word("rd_c3_paddr", {22'h0, paddr}, 32'h010);
    tick();
    expect_ctl("rd_c4_wait", 5'b11000);
    pready = 1; pslverr = 0;
    tick();
    expect_ctl("rd_c5_ack1", 5'b00010);
    expect_word("rd_c5_rdata", rsp_rdata, 32'hDEADBEEF);
    req1 = 0;
    tick();
    expect_ctl("rd_c6_idle", 5'b00000);
    expect_word("rd_c6_rdata_clr", rsp_rdata, 32'h0);
  endtask

  task automatic test_contention();
    logic [9:0] exp_addr;
    test_reset();
    req0 = 1; wr0 = 1; addr0 = 10'h020; wdata0 = 32'h11111111;
    req1 = 1; wr1 = 1; addr1 = 10'h021; wdata1 = 32'h22222222;
    for (int k = 0; k < 4; k++) begin
      exp_addr = (k % 2 == 0) ? 10'h020 : 10'h021;
      tick();
      expect_ctl($sformatf("rr%0d_setup", k), 5'b10000);
      expect_word($sformatf("rr%0d_paddr", k), {22'h0, paddr}, {22'h0, exp_addr});
      tick();
      expect_ctl($sformatf("rr%0d_access", k), 5'b11000);
      tick();
      expect_ctl($sformatf("rr%0d_ack", k), (k % 2 == 0) ? 5'b00100 : 5'b00010);
    end
    req0 = 0; req1 = 0;
    tick();
    expect_ctl("rr_idle", 5'b00000);
    expect_word("rr_mem1", mem[10'h021], 32'h22222222);
  endtask

  task automatic test_error();
    req0 = 1; wr0 = 0; addr0 = 10'h3FF; pready = 1; pslverr = 1;
    tick(); tick(); tick();
    expect_ctl("err_ack0", 5'b00101);
    expect_word("err_rdata", rsp_rdata, 32'h0);
    req0 = 0; pslverr = 0;
    tick();
    expect_ctl("err_clr", 5'b00000);
  endtask

  task automatic test_reset_mid();
    bit seen;
    // Requester 0 finished last, so the pointer now favours requester 1.
    req1 = 1; wr1 = 0; addr1 = 10'h010; pready = 0;
    tick(); tick(); tick();
    expect_ctl("rst_mid_access", 5'b11000);
    preset = 1;
    tick();
    expect_ctl("rst_mid_abort", 5'b00000);
    preset = 0;
    req0 = 1; wr0 = 1; addr0 = 10'h030; wdata0 = 32'h12345678;
    addr1 = 10'h031; pready = 1;
    tick();
    expect_word("rst_ptr_grant0", {22'h0, paddr}, 32'h030);
    tick(); tick();
    expect_ctl("rst_ack0", 5'b00100);
    req0 = 0;
    seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      tick();
      if (ack1) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL rst_ack1_timeout got no ack1 expected ack1 within 8 cycles");
    end
    req1 = 0;
    tick();
  endtask

`ifdef APB_TIMEOUT_EN
  task automatic test_timeout();
    mem[10'h040] = 32'hCAFEF00D;
    req0 = 1; wr0 = 0; addr0 = 10'h040; pready = 0;
    tick();
    for (int i = 0; i < 16; i++) begin
      tick();
      expect_ctl($sformatf("to_access%0d", i), 5'b11000);
    end
    tick();
    expect_ctl("to_abort_ack", 5'b00101);
    expect_word("to_abort_rdata", rsp_rdata, 32'h0);
    req0 = 0;
    tick();
    // pready on the 16th ACCESS cycle completes normally.
    req0 = 1;
    tick();
    for (int i = 0; i < 16; i++) begin
      tick();
      if (i == 15) pready = 1;
    end
    tick();
    expect_ctl("to_last_ok", 5'b00100);
    expect_word("to_last_rdata", rsp_rdata, 32'hCAFEF00D);
    req0 = 0;
    tick();
  endtask
`else
  task automatic test_no_timeout();
    req0 = 1; wr0 = 0; addr0 = 10'h040; pready = 0;
    tick();
    for (int i = 0; i < 24; i++) tick();
    expect_ctl("nto_still_waiting", 5'b11000);
    pready = 1;
    tick();
    expect_ctl("nto_ack", 5'b00100);
    req0 = 0;
    tick();
  endtask
`endif

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    test_reset();
    test_single_write();
    test_read_wait();
    test_contention();
    test_error();
    test_reset_mid();
`ifdef APB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_arb_master.md
Name: apb_arb_master

Overview:
- Two-requester APB master that shares one APB slave port (e.g. the 1024x32 APB memory slave) between two local requesters.
- Arbitrates round-robin and sequences the APB IDLE/SETUP/ACCESS protocol.
- Waits on pready, then returns read data and the error status to the granted requester with a one-cycle ack.
- Sits between local bus users (CPU stub, DMA stub) and the APB slave.

Parameters:
- ADDR_WIDTH, 10, APB address width (matches 1024-word slave).
- DATA_WIDTH, 32, APB data width.
- TIMEOUT_CYCLES, 16, ACCESS-phase wait limit; used only with APB_TIMEOUT_EN.

Ports:
- pclk  in  1  APB clock; all logic on rising edge.
- preset  in  1  reset, synchronous, active-high.
- req0 / req1  in  1  transfer request, held until ack.
- wr0 / wr1  in  1  1 = write, 0 = read; stable while req is high.
- addr0 / addr1  in  ADDR_WIDTH  transfer address.
- wdata0 / wdata1  in  DATA_WIDTH  write data.
- ack0 / ack1  out  1  one-cycle completion pulse.
- rsp_rdata  out  DATA_WIDTH  read data; valid while ack is high.
- rsp_err  out  1  completion error; valid while ack is high.
- paddr  out  ADDR_WIDTH  APB address.
- pwdata  out  DATA_WIDTH  APB write data.
- pwrite  out  1  APB direction.
- pselx  out  1  APB select.
- penable  out  1  APB enable.
- prdata  in  DATA_WIDTH  APB read data.
- pready  in  1  APB ready.
- pslverr  in  1  APB slave error.

Behaviour:
- Reset (preset=1 at a pclk edge): state=IDLE; all outputs 0; priority pointer=0 (requester 0 favoured first).
- FSM states: IDLE, SETUP, ACCESS (2-bit encoding).
- IDLE:
  - pselx=0, penable=0.
  - Eligible requester: req high and its own ack not high this cycle. This blocks a re-grant while the requester drops req.
  - One eligible: grant it.
  - Both eligible: grant the pointer side.
  - Next edge: latch gnt, addr, wdata, wr into paddr/pwdata/pwrite; go to SETUP.
  - No eligible: stay in IDLE.
- SETUP: pselx=1, penable=0; go to ACCESS next edge unconditionally.
- ACCESS:
  - pselx=1, penable=1; paddr, pwdata and pwrite held stable.
  - pready=0: stay in ACCESS.
  - pready=1 at an edge:
    - ack of granted requester <= 1.
    - rsp_rdata <= prdata on reads; 0 on writes.
    - rsp_err <= pslverr.
    - pointer <= other requester.
    - pselx, penable <= 0; state <= IDLE.
- ack, rsp_rdata and rsp_err are each high/valid for exactly one cycle, then cleared.
- Latency, zero-wait slave: req seen in IDLE cycle 0, SETUP cycle 1, ACCESS cycle 2, ack cycle 3. Each pready wait cycle adds one.
- Requester protocol:
  - Must drop req, or present a new command, on the edge after seeing ack.
  - A req held high continuously is re-granted only after the ack cycle.
- Request changes while not granted are tolerated. Command fields are sampled only at the IDLE->SETUP edge.
- Reset mid-transfer: return to IDLE next edge, no ack issued, outputs 0.
- pslverr is ignored unless pready=1.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- With it:
  - An ACCESS-cycle counter (clog2(TIMEOUT_CYCLES)+1 bits) starts at 0 on SETUP->ACCESS.
  - If TIMEOUT_CYCLES ACCESS cycles elapse with pready=0, abort: ack the granted requester, rsp_err=1, rsp_rdata=0, go to IDLE.
  - pready=1 on the final counted cycle counts as a normal completion.
- Without it: ACCESS waits indefinitely; no counter is built.

Decomposition:
- Shared package apb_pkg:
  - ADDR_WIDTH/DATA_WIDTH defaults.
  - State encoding constants IDLE=2'b00, SETUP=2'b01, ACCESS=2'b10 (shared with the slave).
- One natural sub-module: apb_rr_arb2 (2-way round-robin grant logic plus pointer register).

Test Plan:
- Single write: req0, wr0=1, addr0=0x010, wdata0=0xDEADBEEF, pready=1.
  -> pselx high cycles 1-2, penable cycle 2, ack0 cycle 3, rsp_err=0.
- Read-back: req1, wr1=0, addr1=0x010; slave returns 0xDEADBEEF after 2 wait states.
  -> ack1 in cycle 5, rsp_rdata=0xDEADBEEF.
- Contention: req0 and req1 asserted in the same cycle from reset, both held.
  -> grant order 0, 1, 0, 1; one IDLE cycle between transfers; no double grant.
- Error: pslverr=1 with pready=1 on addr 0x3FF.
  -> ack0 with rsp_err=1.
- Reset mid-ACCESS: preset=1 while pready=0.
  -> next cycle pselx=0, penable=0, no ack; pointer back to 0.
- APB_TIMEOUT_EN with TIMEOUT_CYCLES=16, pready held 0.
  -> ack after 16 ACCESS cycles, rsp_err=1, rsp_rdata=0.
